// File: rtl/axi_pwm_irq_ctrl_pkg.sv
// Shared definitions for the AXI4-Lite PWM/interrupt controller: register map,
// response codes, FSM state types and byte-lane helpers.
package axi_pwm_pkg;

    localparam int unsigned OFF_CTRL     = 32'h00;
    localparam int unsigned OFF_PERIOD   = 32'h04;
    localparam int unsigned OFF_IRQ_EN   = 32'h08;
    localparam int unsigned OFF_IRQ_STAT = 32'h0C;
    localparam int unsigned OFF_DUTY0    = 32'h10;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CENTER = 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {DIR_UP = 1'b0, DIR_DOWN = 1'b1} dir_t;

    typedef enum logic [2:0] {
        WR_INIT, WR_IDLE, WR_AW, WR_W, WR_BOTH, WR_RESP
    } wr_state_t;

    typedef enum logic [1:0] {
        RD_INIT, RD_IDLE, RD_RESP
    } rd_state_t;

    function automatic logic [31:0] byte_mask(input logic [3:0] strb);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{strb[b]}};
        end
        return m;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  strb);
        logic [31:0] m;
        m = byte_mask(strb);
        return (old_v & ~m) | (new_v & m);
    endfunction

endpackage

// File: rtl/axi_pwm_irq_ctrl_if.sv
// AXI4-Lite slave bundle for the PWM controller, with master and slave views.
interface axi_pwm_irq_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic [ADDR_W-1:0] axi_awaddr;
    logic              axi_awvalid;
    logic              axi_awready;
    logic [31:0]       axi_wdata;
    logic [3:0]        axi_wstrb;
    logic              axi_wvalid;
    logic              axi_wready;
    logic [1:0]        axi_bresp;
    logic              axi_bvalid;
    logic              axi_bready;
    logic [ADDR_W-1:0] axi_araddr;
    logic              axi_arvalid;
    logic              axi_arready;
    logic [31:0]       axi_rdata;
    logic [1:0]        axi_rresp;
    logic              axi_rvalid;
    logic              axi_rready;

    modport slave (
        input  axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arvalid, axi_rready,
        output axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );

    modport master (
        output axi_awaddr, axi_awvalid, axi_wdata, axi_wstrb, axi_wvalid,
               axi_bready, axi_araddr, axi_arvalid, axi_rready,
        input  axi_awready, axi_wready, axi_bresp, axi_bvalid,
               axi_arready, axi_rdata, axi_rresp, axi_rvalid
    );
endinterface

// File: rtl/axi_pwm_irq_ctrl_timebase.sv
// Shared PWM timebase: edge-aligned sawtooth or center-aligned triangle counter
// with a one-cycle period event used to reload the active registers.
module pwm_timebase
    import axi_pwm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             center,
    input  logic [CNT_W-1:0] period_act,
    output logic [CNT_W-1:0] cnt,
    output dir_t             dir,
    output logic             pe
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_t             dir_q, dir_d;
    logic             pe_d;

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        pe_d  = 1'b0;
        if (!en || period_act == '0) begin
            cnt_d = '0;
            dir_d = DIR_UP;
        end else if (!center) begin
            dir_d = DIR_UP;
            // >= also recovers cleanly if a mode switch leaves cnt beyond the period
            if (cnt_q >= period_act) begin
                cnt_d = '0;
                pe_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (dir_q == DIR_UP) begin
            if (cnt_q >= period_act) begin
                cnt_d = period_act - CNT_W'(1);
                dir_d = DIR_DOWN;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            if (cnt_q == '0) begin
                cnt_d = CNT_W'(1);
                dir_d = DIR_UP;
                pe_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            dir_q <= DIR_UP;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
        end
    end

    assign cnt = cnt_q;
    assign dir = dir_q;
    assign pe  = pe_d;

endmodule

// File: rtl/axi_pwm_irq_ctrl.sv
// AXI4-Lite PWM generator: register file with shadow/active double buffering,
// per-channel comparators and sticky period-complete interrupts.
module axi_pwm_irq_ctrl
    import axi_pwm_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16,
    parameter int ADDR_W = 7
) (
    input  logic              axi_aclk,
    input  logic              axi_areset,
    axi_pwm_irq_ctrl_if.slave s_axi,
    output logic [NUM_CH-1:0] pwm_out,
    output logic              irq
);

    wr_state_t         wr_state_q, wr_state_d;
    rd_state_t         rd_state_q, rd_state_d;
    logic [ADDR_W-1:0] awaddr_q, awaddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [1:0]        bresp_q, bresp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;

    logic [1:0]        ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [NUM_CH-1:0] irq_en_q, irq_en_d;
    logic [NUM_CH-1:0] irq_stat_q, irq_stat_d;
    logic [CNT_W-1:0]  duty_q [NUM_CH];
    logic [CNT_W-1:0]  duty_d [NUM_CH];

    logic [CNT_W-1:0]  period_act_q, period_act_d;
    logic              center_act_q, center_act_d;
    logic [CNT_W-1:0]  duty_act_q [NUM_CH];
    logic [CNT_W-1:0]  duty_act_d [NUM_CH];
    logic [NUM_CH-1:0] pwm_q, pwm_d;
    logic              irq_q, irq_d;

    logic [CNT_W-1:0]  cnt;
    dir_t              dir_unused;
    logic              pe;
    logic [NUM_CH-1:0] stat_clr;
    logic [31:0]       merged;

    // Misaligned addresses are treated like holes in the map.
    function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
        return (a[1:0] == 2'b00) && (32'(a[ADDR_W-1:2]) < 32'(4 + NUM_CH));
    endfunction

    function automatic int unsigned word_idx(input logic [ADDR_W-1:0] a);
        return 32'(a[ADDR_W-1:2]);
    endfunction

    pwm_timebase #(.CNT_W(CNT_W)) u_timebase (
        .clk        (axi_aclk),
        .rst        (axi_areset),
        .en         (ctrl_q[CTRL_EN]),
        .center     (center_act_q),
        .period_act (period_act_q),
        .cnt        (cnt),
        .dir        (dir_unused),
        .pe         (pe)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        period_d   = period_q;
        irq_en_d   = irq_en_q;
        duty_d     = duty_q;
        stat_clr   = '0;
        merged     = '0;
        case (wr_state_q)
            WR_INIT: wr_state_d = WR_IDLE;
            WR_IDLE: begin
                if (s_axi.axi_awvalid) awaddr_d = s_axi.axi_awaddr;
                if (s_axi.axi_wvalid) begin
                    wdata_d = s_axi.axi_wdata;
                    wstrb_d = s_axi.axi_wstrb;
                end
                if (s_axi.axi_awvalid && s_axi.axi_wvalid) wr_state_d = WR_BOTH;
                else if (s_axi.axi_awvalid)                wr_state_d = WR_AW;
                else if (s_axi.axi_wvalid)                 wr_state_d = WR_W;
            end
            WR_AW: begin
                if (s_axi.axi_wvalid) begin
                    wdata_d    = s_axi.axi_wdata;
                    wstrb_d    = s_axi.axi_wstrb;
                    wr_state_d = WR_BOTH;
                end
            end
            WR_W: begin
                if (s_axi.axi_awvalid) begin
                    awaddr_d   = s_axi.axi_awaddr;
                    wr_state_d = WR_BOTH;
                end
            end
            WR_BOTH: begin
                wr_state_d = WR_RESP;
                bresp_d    = is_mapped(awaddr_q) ? RESP_OKAY : RESP_SLVERR;
                if (is_mapped(awaddr_q)) begin
                    case (word_idx(awaddr_q))
                        OFF_CTRL / 4: begin
                            merged = merge_bytes({30'b0, ctrl_q}, wdata_q, wstrb_q);
                            ctrl_d = merged[1:0];
                        end
                        OFF_PERIOD / 4: begin
                            merged   = merge_bytes(32'(period_q), wdata_q, wstrb_q);
                            period_d = merged[CNT_W-1:0];
                        end
                        OFF_IRQ_EN / 4: begin
                            merged   = merge_bytes(32'(irq_en_q), wdata_q, wstrb_q);
                            irq_en_d = merged[NUM_CH-1:0];
                        end
                        OFF_IRQ_STAT / 4: begin
                            merged   = wdata_q & byte_mask(wstrb_q);
                            stat_clr = merged[NUM_CH-1:0];
                        end
                        default: begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                if (word_idx(awaddr_q) == OFF_DUTY0 / 4 + 32'(i)) begin
                                    merged    = merge_bytes(32'(duty_q[i]), wdata_q, wstrb_q);
                                    duty_d[i] = merged[CNT_W-1:0];
                                end
                            end
                        end
                    endcase
                end
            end
            WR_RESP: if (s_axi.axi_bready) wr_state_d = WR_IDLE;
            default: wr_state_d = WR_IDLE;
        endcase
    end

    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            RD_INIT: rd_state_d = RD_IDLE;
            RD_IDLE: begin
                if (s_axi.axi_arvalid) begin
                    rd_state_d = RD_RESP;
                    rdata_d    = '0;
                    rresp_d    = is_mapped(s_axi.axi_araddr) ? RESP_OKAY : RESP_SLVERR;
                    if (is_mapped(s_axi.axi_araddr)) begin
                        case (word_idx(s_axi.axi_araddr))
                            OFF_CTRL / 4:     rdata_d = {30'b0, ctrl_q};
                            OFF_PERIOD / 4:   rdata_d = 32'(period_q);
                            OFF_IRQ_EN / 4:   rdata_d = 32'(irq_en_q);
                            OFF_IRQ_STAT / 4: rdata_d = 32'(irq_stat_q);
                            default: begin
                                for (int i = 0; i < NUM_CH; i++) begin
                                    if (word_idx(s_axi.axi_araddr) == OFF_DUTY0 / 4 + 32'(i)) begin
                                        rdata_d = 32'(duty_q[i]);
                                    end
                                end
                            end
                        endcase
                    end
                end
            end
            RD_RESP: if (s_axi.axi_rready) rd_state_d = RD_IDLE;
            default: rd_state_d = RD_IDLE;
        endcase
    end

    // Shadow values follow into the active set freely while stopped, otherwise only at PE.
    always_comb begin
        period_act_d = period_act_q;
        center_act_d = center_act_q;
        duty_act_d   = duty_act_q;
        if (!ctrl_q[CTRL_EN] || pe) begin
            period_act_d = period_q;
            center_act_d = ctrl_q[CTRL_CENTER];
            duty_act_d   = duty_q;
        end
        irq_stat_d = (irq_stat_q & ~stat_clr) | (pe ? irq_en_q : '0);
        irq_d      = |(irq_stat_q & irq_en_q);
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_cmp
            assign pwm_d[gi] = ctrl_q[CTRL_EN] && (period_act_q != '0) && (cnt < duty_act_q[gi]);
        end
    endgenerate

    always_ff @(posedge axi_aclk or posedge axi_areset) begin
        if (axi_areset) begin
            wr_state_q   <= WR_INIT;
            rd_state_q   <= RD_INIT;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            bresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            ctrl_q       <= '0;
            period_q     <= '0;
            irq_en_q     <= '0;
            irq_stat_q   <= '0;
            period_act_q <= '0;
            center_act_q <= 1'b0;
            pwm_q        <= '0;
            irq_q        <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_q[i]     <= '0;
                duty_act_q[i] <= '0;
            end
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            bresp_q      <= bresp_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            ctrl_q       <= ctrl_d;
            period_q     <= period_d;
            irq_en_q     <= irq_en_d;
            irq_stat_q   <= irq_stat_d;
            period_act_q <= period_act_d;
            center_act_q <= center_act_d;
            pwm_q        <= pwm_d;
            irq_q        <= irq_d;
            duty_q       <= duty_d;
            duty_act_q   <= duty_act_d;
        end
    end

    assign s_axi.axi_awready = (wr_state_q == WR_IDLE) || (wr_state_q == WR_W);
    assign s_axi.axi_wready  = (wr_state_q == WR_IDLE) || (wr_state_q == WR_AW);
    assign s_axi.axi_bvalid  = (wr_state_q == WR_RESP);
    assign s_axi.axi_bresp   = bresp_q;
    assign s_axi.axi_arready = (rd_state_q == RD_IDLE);
    assign s_axi.axi_rvalid  = (rd_state_q == RD_RESP);
    assign s_axi.axi_rdata   = rdata_q;
    assign s_axi.axi_rresp   = rresp_q;
    assign pwm_out           = pwm_q;
    assign irq               = irq_q;

endmodule

// File: tb/tb_axi_pwm_irq_ctrl.sv
// Directed bench for axi_pwm_irq_ctrl: reset, edge/center timing, shadow
// reload, interrupts and AXI handshake corner cases.
module tb_axi_pwm_irq_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pwm;
    logic       irq;
    int         total  = 0;
    int         passed = 0;

    axi_pwm_irq_ctrl_if #(.ADDR_W(7)) bus ();

    axi_pwm_irq_ctrl #(.NUM_CH(8), .CNT_W(16), .ADDR_W(7)) dut (
        .axi_aclk   (clk),
        .axi_areset (rst),
        .s_axi      (bus),
        .pwm_out    (pwm),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic axi_write(input logic [6:0] a, input logic [31:0] d,
                             input logic [3:0] s, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, b_done = 0, aw_hs, w_hs;
        int n = 0;
        bus.axi_awaddr = a; bus.axi_wdata = d; bus.axi_wstrb = s;
        bus.axi_awvalid = 1'b1; bus.axi_wvalid = 1'b1;
        resp = 2'bxx;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = bus.axi_awvalid && bus.axi_awready;
            w_hs  = bus.axi_wvalid && bus.axi_wready;
            step(); n++;
            if (aw_hs) begin aw_done = 1; bus.axi_awvalid = 1'b0; end
            if (w_hs)  begin w_done = 1;  bus.axi_wvalid = 1'b0; end
        end
        bus.axi_awvalid = 1'b0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b1;
        while (!b_done && n < 50) begin
            if (bus.axi_bvalid) begin
                resp = bus.axi_bresp; b_done = 1;
            end
            step(); n++;
        end
        bus.axi_bready = 1'b0;
        if (!b_done) begin
            total++;
            $display("FAIL write_timeout addr=%h got no bvalid, required response within 50 cycles", a);
        end
    endtask

    task automatic axi_read(input logic [6:0] a, output logic [31:0] d, output logic [1:0] resp);
        bit ar_done = 0, r_done = 0, hs;
        int n = 0;
        bus.axi_araddr = a; bus.axi_arvalid = 1'b1;
        d = 'x; resp = 2'bxx;
        while (!ar_done && n < 50) begin
            hs = bus.axi_arready;
            step(); n++;
            if (hs) ar_done = 1;
        end
        bus.axi_arvalid = 1'b0;
        bus.axi_rready = 1'b1;
        while (!r_done && n < 50) begin
            if (bus.axi_rvalid) begin
                d = bus.axi_rdata; resp = bus.axi_rresp; r_done = 1;
            end
            step(); n++;
        end
        bus.axi_rready = 1'b0;
        if (!r_done) begin
            total++;
            $display("FAIL read_timeout addr=%h got no rvalid, required response within 50 cycles", a);
        end
    endtask

    task automatic wait_pe();
        int n = 0;
        while (dut.u_timebase.pe !== 1'b1 && n < 100) begin
            step(); n++;
        end
        if (n >= 100) begin
            total++;
            $display("FAIL pe_timeout no period event within 100 cycles");
        end
    endtask

    task automatic test_reset();
        logic [49:0] outs;
        logic [1:0]  r;
        logic [31:0] d;
        repeat (3) @(posedge clk);
        #1;
        outs = {bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_arready, bus.axi_rvalid,
                bus.axi_bresp, bus.axi_rresp, bus.axi_rdata, pwm, irq};
        total++;
        if (outs !== '0) $display("FAIL reset_outputs got %h required 0", outs);
        else passed++;
        rst = 1'b0;
        step(); step();
        bus.axi_awaddr = 7'h04; bus.axi_awvalid = 1'b1;
        total++;
        if (bus.axi_awready !== 1'b1) $display("FAIL awready_idle got %b required 1", bus.axi_awready);
        else passed++;
        step();
        bus.axi_awvalid = 1'b0;
        total++;
        if ({bus.axi_awready, bus.axi_wready} !== 2'b01)
            $display("FAIL aw_captured got %b required 01", {bus.axi_awready, bus.axi_wready});
        else passed++;
        rst = 1'b1;
        #1;
        outs = {bus.axi_awready, bus.axi_wready, bus.axi_bvalid, bus.axi_arready, bus.axi_rvalid,
                bus.axi_bresp, bus.axi_rresp, bus.axi_rdata, pwm, irq};
        total++;
        if (outs !== '0) $display("FAIL reset_midwrite got %h required 0", outs);
        else passed++;
        step();
        rst = 1'b0;
        step(); step();
        axi_write(7'h04, 32'd5, 4'hF, r);
        total++;
        if (r !== 2'b00) $display("FAIL post_reset_bresp got %b required 00", r);
        else passed++;
        axi_read(7'h04, d, r);
        total++;
        if ({r, d} !== {2'b00, 32'd5}) $display("FAIL post_reset_period got %b/%h required 00/5", r, d);
        else passed++;
    endtask

    task automatic test_edge();
        logic [1:0] r;
        logic       s [30];
        logic       p [30];
        int         highs = 0, pes = 0, first = -1, second = -1;
        bit         periodic = 1;
        axi_write(7'h04, 32'd9, 4'hF, r);
        axi_write(7'h10, 32'd3, 4'hF, r);
        axi_write(7'h00, 32'd1, 4'hF, r);
        repeat (25) step();
        for (int k = 0; k < 30; k++) begin
            s[k] = pwm[0];
            p[k] = dut.u_timebase.pe;
            step();
        end
        for (int k = 0; k < 10; k++) highs += int'(s[k]);
        for (int k = 0; k < 20; k++) if (s[k] !== s[k+10]) periodic = 0;
        for (int k = 0; k < 30; k++) begin
            if (p[k] === 1'b1) begin
                pes++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        total++;
        if (highs != 3) $display("FAIL edge_duty_high got %0d required 3", highs);
        else passed++;
        total++;
        if (!periodic) $display("FAIL edge_periodic got non-repeating pattern required period 10");
        else passed++;
        total++;
        if (pes != 3 || second - first != 10)
            $display("FAIL edge_pe got %0d events spacing %0d required 3 spacing 10", pes, second - first);
        else passed++;
    endtask

    task automatic test_mid_period();
        logic [1:0] r;
        logic       s [22];
        int         h1 = 0, h2 = 0;
        wait_pe();
        fork
            axi_write(7'h10, 32'd7, 4'hF, r);
            for (int k = 1; k <= 21; k++) begin
                step();
                s[k] = pwm[0];
            end
        join
        for (int k = 2; k <= 11; k++) h1 += int'(s[k]);
        for (int k = 12; k <= 21; k++) h2 += int'(s[k]);
        total++;
        if (h1 != 3) $display("FAIL mid_period_old got %0d high required 3", h1);
        else passed++;
        total++;
        if (h2 != 7) $display("FAIL mid_period_new got %0d high required 7", h2);
        else passed++;
    endtask

    task automatic test_irq();
        logic [1:0]  r;
        logic [31:0] d;
        axi_write(7'h0C, 32'hFF, 4'hF, r);
        axi_write(7'h08, 32'h05, 4'hF, r);
        repeat (12) step();
        axi_read(7'h0C, d, r);
        total++;
        if (d !== 32'h05) $display("FAIL irq_stat_set got %h required 05", d);
        else passed++;
        total++;
        if (irq !== 1'b1) $display("FAIL irq_level got %b required 1", irq);
        else passed++;
        wait_pe();
        axi_write(7'h0C, 32'h01, 4'hF, r);
        axi_read(7'h0C, d, r);
        total++;
        if (d !== 32'h04) $display("FAIL w1c_clear got %h required 04", d);
        else passed++;
        // Clear of bit 2 is committed in the very cycle the next PE fires.
        wait_pe();
        repeat (9) step();
        axi_write(7'h0C, 32'h04, 4'hF, r);
        axi_read(7'h0C, d, r);
        total++;
        if (d !== 32'h05) $display("FAIL w1c_set_wins got %h required 05", d);
        else passed++;
        axi_write(7'h08, 32'h00, 4'hF, r);
        step(); step();
        total++;
        if (irq !== 1'b0) $display("FAIL irq_masked got %b required 0", irq);
        else passed++;
        axi_read(7'h0C, d, r);
        total++;
        if (d !== 32'h05) $display("FAIL stat_retained got %h required 05", d);
        else passed++;
    endtask

    task automatic test_center();
        logic [1:0]  r;
        logic [15:0] c;
        logic [7:0]  pat;
        logic        pe_end;
        int          exp_c [8] = '{1, 2, 3, 4, 3, 2, 1, 0};
        axi_write(7'h04, 32'd4, 4'hF, r);
        axi_write(7'h14, 32'd2, 4'hF, r);
        axi_write(7'h00, 32'd3, 4'hF, r);
        repeat (30) step();
        wait_pe();
        total++;
        if (dut.u_timebase.cnt !== 16'd0) $display("FAIL center_pe_cnt got %0d required 0", dut.u_timebase.cnt);
        else passed++;
        pe_end = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            c = dut.u_timebase.cnt;
            pat[k-1] = pwm[1];
            if (k == 8) pe_end = dut.u_timebase.pe;
            total++;
            if (c !== 16'(exp_c[k-1])) $display("FAIL center_cnt step %0d got %0d required %0d", k, c, exp_c[k-1]);
            else passed++;
        end
        // cnt<2 holds at 1,0,1 of each 8-step cycle, one cycle late at the pin.
        total++;
        if (pat !== 8'b1000_0011) $display("FAIL center_pwm got %b required 10000011", pat);
        else passed++;
        total++;
        if (pe_end !== 1'b1) $display("FAIL center_pe_period got %b required 1", pe_end);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  r;
        logic [31:0] d;
        bit          quiet = 1, held = 1;
        bus.axi_awaddr = 7'h18; bus.axi_awvalid = 1'b1;
        bus.axi_wdata = 32'h55; bus.axi_wstrb = 4'hF;
        total++;
        if (bus.axi_awready !== 1'b1) $display("FAIL split_awready got %b required 1", bus.axi_awready);
        else passed++;
        step();
        bus.axi_awvalid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            if (bus.axi_bvalid !== 1'b0 || bus.axi_wready !== 1'b1) quiet = 0;
            step();
        end
        bus.axi_wvalid = 1'b1;
        if (bus.axi_bvalid !== 1'b0 || bus.axi_wready !== 1'b1) quiet = 0;
        total++;
        if (!quiet) $display("FAIL split_wait got bvalid/wready wrong required 0/1 while W pending");
        else passed++;
        step();
        bus.axi_wvalid = 1'b0;
        step();
        for (int k = 0; k < 5; k++) begin
            if (bus.axi_bvalid !== 1'b1) held = 0;
            step();
        end
        total++;
        if (!held) $display("FAIL bvalid_held got drop required held 5 cycles");
        else passed++;
        bus.axi_bready = 1'b1;
        total++;
        if (bus.axi_bresp !== 2'b00) $display("FAIL split_bresp got %b required 00", bus.axi_bresp);
        else passed++;
        step();
        bus.axi_bready = 1'b0;
        total++;
        if (bus.axi_bvalid !== 1'b0) $display("FAIL bvalid_cleared got %b required 0", bus.axi_bvalid);
        else passed++;
        axi_read(7'h18, d, r);
        total++;
        if ({r, d} !== {2'b00, 32'h55}) $display("FAIL split_readback got %b/%h required 00/55", r, d);
        else passed++;
        axi_write(7'h1C, 32'h0000ABCD, 4'b0001, r);
        axi_read(7'h1C, d, r);
        total++;
        if (d !== 32'h000000CD) $display("FAIL wstrb_lane got %h required 000000cd", d);
        else passed++;
        axi_write(7'h04, 32'hFFFF0009, 4'hF, r);
        axi_read(7'h04, d, r);
        total++;
        if (d !== 32'h00000009) $display("FAIL period_truncate got %h required 00000009", d);
        else passed++;
        axi_write(7'h40, 32'h1234, 4'hF, r);
        total++;
        if (r !== 2'b10) $display("FAIL unmapped_bresp got %b required 10", r);
        else passed++;
        axi_read(7'h40, d, r);
        total++;
        if ({r, d} !== {2'b10, 32'h0}) $display("FAIL unmapped_read got %b/%h required 10/0", r, d);
        else passed++;
    endtask

    initial begin
        bus.axi_awaddr = '0; bus.axi_awvalid = 1'b0;
        bus.axi_wdata = '0;  bus.axi_wstrb = '0; bus.axi_wvalid = 1'b0;
        bus.axi_bready = 1'b0;
        bus.axi_araddr = '0; bus.axi_arvalid = 1'b0; bus.axi_rready = 1'b0;
        test_reset();
        test_edge();
        test_mid_period();
        test_irq();
        test_center();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
